f1_start_sequencer: RTL and testbench
=====================================

// Module: f1_start_sequencer
// PURPOSE
//  Race-start sequencer directly upstream of the F1 start-light FSM.
//  Drives that FSM's en (one-cycle advance pulses) and rst (resync pulse).
//  Lights step on every LIGHT_MS ms; all-red holds for a pseudo-random time; lights go out.
//  Then times the driver's reaction until btn, flagging jump starts.
// PARAMETERS
//  LIGHT_MS      1000   ticks between successive light advances (>=1)
//  MIN_HOLD_MS   200    minimum all-red hold, ticks (>=1)
//  HOLD_STEP_MS  16     hold increment per LFSR unit; hold = MIN_HOLD_MS + lfsr*HOLD_STEP_MS
//  MAX_REACT_MS  4095   reaction timeout, ticks (< 16'hFFFF)
// PORTS
//  clk         in   1   clock
//  rst         in   1   synchronous, active-high reset
//  tick        in   1   1 ms strobe, one clk wide (upstream divider)
//  start       in   1   one-cycle request to begin a sequence
//  btn         in   1   driver button, level, already synchronised to clk
//  fsm_en      out  1   one-cycle advance pulse to light FSM
//  fsm_rst     out  1   one-cycle resync pulse to light FSM
//  busy        out  1   high in any state other than IDLE
//  react_ms    out  16  last reaction time in ticks; 16'hFFFF = timeout
//  react_valid out  1   one-cycle strobe: react_ms updated
//  jump_start  out  1   one-cycle strobe: btn edge before lights out
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0, react_ms=0; LFSR=7'h01; btn_q=0; counters 0.
//  btn_edge = btn & ~btn_q; btn_q registered every cycle.
//  LFSR: 7-bit Fibonacci, taps x^7+x^6+1, advances every clk (free-running), never 0.
//  IDLE: start -> LIGHTS; fsm_rst=1 that cycle; light_cnt=0, pulses=0.
//  LIGHTS: on tick, if light_cnt==LIGHT_MS-1:
//   - fsm_en=1, light_cnt=0, pulses++; else light_cnt++.
//   - The 8th pulse -> HOLD; load hold_cnt = MIN_HOLD_MS + lfsr*HOLD_STEP_MS.
//   - lfsr is sampled that cycle.
//  HOLD: on tick, if hold_cnt==1 -> fsm_en=1 (lights out), react_cnt=0, go REACT; else hold_cnt--.
//  REACT: btn_edge -> react_ms=react_cnt, react_valid=1, -> IDLE.
//   - Otherwise on tick react_cnt++.
//   - When react_cnt reaches MAX_REACT_MS: react_ms=16'hFFFF, react_valid=1, -> IDLE.
//  Jump start: btn_edge in LIGHTS or HOLD -> jump_start=1, fsm_rst=1, -> IDLE.
//   - No fsm_en that cycle; react_ms unchanged.
//  Priority in one cycle: rst > btn_edge > tick. A tick coinciding with btn_edge is not counted.
//  start while busy: ignored. btn held high through lights out: no edge, so no reaction captured.
//  Outputs fsm_en, fsm_rst, react_valid, jump_start are registered; each rises one cycle after its cause.
//  busy is decoded from state.
//  Width: hold_cnt, react_cnt 16-bit unsigned; max hold 200+127*16=2232 fits.
// STRUCTURE
//  f1_pkg:
//   - typedef enum logic [1:0] {IDLE, LIGHTS, HOLD, REACT} seq_state_t.
//   - LFSR_SEED=7'h01; LFSR_TAPS=7'b1100000; NUM_LIGHTS=8.
//  Sub-module f1_lfsr7 (clk, rst, q[6:0]); remainder is one FSM plus counters.
// TESTING (bench params: LIGHT_MS=4, MIN_HOLD_MS=2, HOLD_STEP_MS=1, MAX_REACT_MS=20)
//  1. Reset, tick=1 continuous -> all outputs 0, busy=0; LFSR reads 7'h01 after reset.
//  2. start, tick=1, btn=0 -> fsm_rst once; 8 fsm_en pulses 4 cycles apart.
//     Then hold of 2+lfsr ticks, 9th fsm_en pulse, busy stays 1.
//  3. As 2, btn rises 10 ticks after entering REACT -> react_ms=10, react_valid one cycle, busy=0.
//  4. btn rises during LIGHTS (after 3rd pulse) -> jump_start=1, fsm_rst=1, no further fsm_en.
//     react_ms keeps its prior value.
//  5. No btn after lights out -> after 20 ticks react_ms=16'hFFFF, react_valid=1, state IDLE.
//  6. start pulsed mid-HOLD -> ignored.
//     rst mid-HOLD -> all outputs 0 next cycle, no fsm_en afterwards.

Source files
------------

// File: rtl/f1_pkg.sv
// f1_pkg: shared state encoding and LFSR constants for the F1 start sequencer.
package f1_pkg;
    typedef enum logic [1:0] {IDLE, LIGHTS, HOLD, REACT} seq_state_t;
    localparam logic [6:0] LFSR_SEED  = 7'h01;
    localparam logic [6:0] LFSR_TAPS  = 7'b1100000;
    localparam int         NUM_LIGHTS = 8;
endpackage

// File: rtl/f1_lfsr7.sv
// f1_lfsr7: free-running 7-bit Fibonacci LFSR (x^7+x^6+1), maximal length, never zero.
module f1_lfsr7
    import f1_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    output logic [6:0] q
);
    logic [6:0] r_q;
    always_ff @(posedge clk)
        r_q <= rst ? LFSR_SEED : {r_q[5:0], ^(r_q & LFSR_TAPS)};
    assign q = r_q;
endmodule

// File: rtl/f1_start_sequencer.sv
// f1_start_sequencer: paces the start-light FSM through eight lights and a random
// all-red hold, then times the driver's reaction and flags jump starts.
module f1_start_sequencer
    import f1_pkg::*;
#(
    parameter int LIGHT_MS     = 1000,
    parameter int MIN_HOLD_MS  = 200,
    parameter int HOLD_STEP_MS = 16,
    parameter int MAX_REACT_MS = 4095
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        start,
    input  logic        btn,
    output logic        fsm_en,
    output logic        fsm_rst,
    output logic        busy,
    output logic [15:0] react_ms,
    output logic        react_valid,
    output logic        jump_start
);
    seq_state_t  r_state;
    logic [15:0] r_light_cnt, r_hold_cnt, r_react_cnt, r_react_ms;
    logic [3:0]  r_pulses;
    logic        r_btn_q, r_fsm_en, r_fsm_rst, r_react_valid, r_jump_start;
    logic [6:0]  w_lfsr;
    logic        w_btn_edge;
    logic [15:0] w_hold_load;

    f1_lfsr7 u_lfsr (.clk(clk), .rst(rst), .q(w_lfsr));

    assign w_btn_edge  = btn & ~r_btn_q;
    assign w_hold_load = 16'(MIN_HOLD_MS + int'(w_lfsr) * HOLD_STEP_MS);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_light_cnt   <= '0;
            r_hold_cnt    <= '0;
            r_react_cnt   <= '0;
            r_react_ms    <= '0;
            r_pulses      <= '0;
            r_btn_q       <= 1'b0;
            r_fsm_en      <= 1'b0;
            r_fsm_rst     <= 1'b0;
            r_react_valid <= 1'b0;
            r_jump_start  <= 1'b0;
        end else begin
            r_btn_q       <= btn;
            r_fsm_en      <= 1'b0;
            r_fsm_rst     <= 1'b0;
            r_react_valid <= 1'b0;
            r_jump_start  <= 1'b0;
            unique case (r_state)
                IDLE: if (start) begin
                    r_state     <= LIGHTS;
                    r_fsm_rst   <= 1'b1;
                    r_light_cnt <= '0;
                    r_pulses    <= '0;
                end
                LIGHTS, HOLD: if (w_btn_edge) begin
                    r_state      <= IDLE;
                    r_jump_start <= 1'b1;
                    r_fsm_rst    <= 1'b1;
                end else if (tick && r_state == LIGHTS) begin
                    if (r_light_cnt == 16'(LIGHT_MS - 1)) begin
                        r_fsm_en    <= 1'b1;
                        r_light_cnt <= '0;
                        r_pulses    <= r_pulses + 4'd1;
                        if (r_pulses == 4'(NUM_LIGHTS - 1)) begin
                            r_state    <= HOLD;
                            r_hold_cnt <= w_hold_load;
                        end
                    end else
                        r_light_cnt <= r_light_cnt + 16'd1;
                end else if (tick) begin
                    if (r_hold_cnt == 16'd1) begin
                        r_state     <= REACT;
                        r_fsm_en    <= 1'b1;
                        r_react_cnt <= '0;
                    end else
                        r_hold_cnt <= r_hold_cnt - 16'd1;
                end
                REACT: if (w_btn_edge) begin
                    r_state       <= IDLE;
                    r_react_ms    <= r_react_cnt;
                    r_react_valid <= 1'b1;
                end else if (tick) begin
                    // the tick that would bring the count to the limit is the timeout
                    if (r_react_cnt == 16'(MAX_REACT_MS - 1)) begin
                        r_state       <= IDLE;
                        r_react_ms    <= 16'hFFFF;
                        r_react_valid <= 1'b1;
                    end else
                        r_react_cnt <= r_react_cnt + 16'd1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy        = r_state != IDLE;
    assign fsm_en      = r_fsm_en;
    assign fsm_rst     = r_fsm_rst;
    assign react_ms    = r_react_ms;
    assign react_valid = r_react_valid;
    assign jump_start  = r_jump_start;
endmodule

// File: tb/tb_f1_start_sequencer.sv
// tb_f1_start_sequencer: directed sequences; output events are matched in order
// against an expected-event queue, including spacing between events.
module tb_f1_start_sequencer;
    logic        clk = 1'b0, rst = 1'b1, tick = 1'b1, start = 1'b0, btn = 1'b0;
    logic        fsm_en, fsm_rst, busy, react_valid, jump_start;
    logic [15:0] react_ms;

    f1_start_sequencer #(.LIGHT_MS(4), .MIN_HOLD_MS(2), .HOLD_STEP_MS(1), .MAX_REACT_MS(20)) dut (
        .clk(clk), .rst(rst), .tick(tick), .start(start), .btn(btn),
        .fsm_en(fsm_en), .fsm_rst(fsm_rst), .busy(busy), .react_ms(react_ms),
        .react_valid(react_valid), .jump_start(jump_start)
    );

    always #5 clk = ~clk;

    localparam logic [3:0] EV_EN = 4'b0001, EV_RST = 4'b0010, EV_VALID = 4'b0100, EV_JUMP = 4'b1010;
    typedef struct {
        logic [3:0]  vec;
        int          gap;
        bit          latch;
        logic [15:0] rms;
    } ev_t;
    ev_t sbq[$];

    int tests = 0, fails = 0;
    int cyc = 0, last = 0, hold_exp = 0;
    logic [6:0] m_lfsr = 7'h01, m_prev = 7'h01;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(logic [3:0] v, int g, bit l, logic [15:0] r);
        ev_t e;
        e.vec = v; e.gap = g; e.latch = l; e.rms = r;
        sbq.push_back(e);
    endtask

    // Reference LFSR: x^7+x^6+1, seeded on reset, steps every clock
    always @(posedge clk) begin
        m_prev <= rst ? 7'h01 : m_lfsr;
        m_lfsr <= rst ? 7'h01 : {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[5]};
    end

    always @(negedge clk) begin
        logic [3:0] obs;
        ev_t e;
        cyc++;
        obs = {jump_start, react_valid, fsm_rst, fsm_en};
        if (rst) last = cyc;
        else if (obs != 4'b0) begin
            if (sbq.size() == 0) chk("unexpected_evt", 32'(obs), 32'h0);
            else begin
                e = sbq.pop_front();
                chk("evt_kind", 32'(obs), 32'(e.vec));
                if (e.gap >= 0) chk("evt_gap", cyc - last, e.gap);
                else if (e.gap == -2) chk("hold_gap", cyc - last, hold_exp);
                chk("evt_react_ms", 32'(react_ms), 32'(e.rms));
                if (e.latch) hold_exp = 2 + int'(m_prev);
            end
            last = cyc;
        end
    end

    task automatic start_seq();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_en(int k);
        int seen = 0;
        int n = 0;
        while (seen < k && n < 300) begin
            @(negedge clk);
            n++;
            if (fsm_en) seen++;
        end
        if (seen < k) chk("wait_en_timeout", seen, k);
    endtask

    task automatic push_lights(logic [15:0] r, bit with_lights_out);
        push(EV_RST, -1, 1'b0, r);
        for (int i = 0; i < 7; i++) push(EV_EN, 4, 1'b0, r);
        push(EV_EN, 4, 1'b1, r);
        if (with_lights_out) push(EV_EN, -2, 1'b0, r);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_outs", 32'({fsm_en, fsm_rst, react_valid, jump_start, busy}), 32'h0);
        chk("rst_react_ms", 32'(react_ms), 32'h0);
        chk("rst_lfsr", 32'(dut.u_lfsr.q), 32'h01);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_outs", 32'({fsm_en, fsm_rst, react_valid, jump_start, busy}), 32'h0);

        push_lights(16'd0, 1'b1);
        push(EV_VALID, 11, 1'b0, 16'd10);
        start_seq();
        chk("busy_lights", 32'(busy), 32'h1);
        wait_en(9);
        chk("busy_react", 32'(busy), 32'h1);
        repeat (10) @(negedge clk);
        btn = 1'b1;
        repeat (3) @(negedge clk);
        chk("busy_after_react", 32'(busy), 32'h0);
        btn = 1'b0;
        repeat (3) @(negedge clk);

        push(EV_RST, -1, 1'b0, 16'd10);
        for (int i = 0; i < 3; i++) push(EV_EN, 4, 1'b0, 16'd10);
        push(EV_JUMP, 1, 1'b0, 16'd10);
        start_seq();
        wait_en(3);
        btn = 1'b1;
        repeat (40) @(negedge clk);
        chk("busy_after_jump", 32'(busy), 32'h0);
        chk("react_ms_kept", 32'(react_ms), 32'd10);
        btn = 1'b0;
        repeat (3) @(negedge clk);

        push_lights(16'd10, 1'b1);
        push(EV_VALID, 20, 1'b0, 16'hFFFF);
        start_seq();
        wait_en(9);
        repeat (25) @(negedge clk);
        chk("busy_after_timeout", 32'(busy), 32'h0);
        chk("timeout_react_ms", 32'(react_ms), 32'hFFFF);

        push_lights(16'hFFFF, 1'b0);
        start_seq();
        wait_en(8);
        start_seq();
        chk("busy_start_ignored", 32'(busy), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midhold_rst_outs", 32'({fsm_en, fsm_rst, react_valid, jump_start, busy}), 32'h0);
        chk("midhold_rst_react_ms", 32'(react_ms), 32'h0);
        repeat (40) @(negedge clk);
        chk("post_rst_idle", 32'(busy), 32'h0);
        chk("sb_empty", sbq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
